// File: rtl/wire_seq_pkg.sv
// Shared encodings and widths for the wire-cut sequence controller.
// Included by every file of the block; see wire_seq_ctrl.sv for WIRE_SEQ_STRIKES_EN.
package wire_seq_pkg;
  localparam int WIRE_IDX_W = 3;
  localparam int STRIKE_W   = 3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARMED    = 2'd1,
    ST_DEFUSED  = 2'd2,
    ST_EXPLODED = 2'd3
  } state_e;

  // Saturating strike increment: never counts past the explosion limit.
  function automatic logic [STRIKE_W-1:0] sat_inc(input logic [STRIKE_W-1:0] v,
                                                  input logic [STRIKE_W-1:0] lim);
    return (v >= lim) ? lim : v + 1'b1;
  endfunction
endpackage

// File: rtl/wire_seq_ctrl_if.sv
// Handshake bundle between the game logic (master) and wire_seq_ctrl (slave).
interface wire_seq_ctrl_if #(parameter int NUM_WIRES = 6);
  import wire_seq_pkg::*;

  logic                    arm;
  logic [3*NUM_WIRES-1:0]  order;
  logic [NUM_WIRES-1:0]    wire_lvl;
  logic                    timeout;
  logic [1:0]              state;
  logic [WIRE_IDX_W-1:0]   step;
  logic [STRIKE_W-1:0]     strikes;
  logic                    strike_p;
  logic                    arm_err;

  modport master (output arm, order, wire_lvl, timeout,
                  input  state, step, strikes, strike_p, arm_err);
  modport slave  (input  arm, order, wire_lvl, timeout,
                  output state, step, strikes, strike_p, arm_err);
endinterface

// File: rtl/wire_cut_detect.sv
// Falling-edge detector for wire lines: reports newly cut wires, whether exactly
// one or several were cut this cycle, and the lowest cut wire index.
module wire_cut_detect
  import wire_seq_pkg::*;
#(
  parameter int NUM_WIRES = 6
) (
  input  logic [NUM_WIRES-1:0]  prev,
  input  logic [NUM_WIRES-1:0]  wire_lvl,
  input  logic [NUM_WIRES-1:0]  cut_mask,
  output logic [NUM_WIRES-1:0]  cut_vec,
  output logic                  single_cut,
  output logic                  multi_cut,
  output logic [WIRE_IDX_W-1:0] cut_idx
);
  always_comb begin
    cut_vec = prev & ~wire_lvl & ~cut_mask;
    cut_idx = '0;
    for (int i = NUM_WIRES - 1; i >= 0; i--) begin
      if (cut_vec[i]) cut_idx = WIRE_IDX_W'(i);
    end
    single_cut = ($countones(cut_vec) == 1);
    multi_cut  = ($countones(cut_vec) > 1);
  end
endmodule

// File: rtl/wire_seq_ctrl.sv
// Wire-cut defusal sequencer. Define WIRE_SEQ_STRIKES_EN to allow MAX_STRIKES
// wrong cuts before explosion; otherwise the first wrong cut detonates.
module wire_seq_ctrl
  import wire_seq_pkg::*;
#(
  parameter int NUM_WIRES   = 6,
  parameter int SEQ_LEN     = 6,
  parameter int MAX_STRIKES = 3
) (
  input  logic            clk,
  input  logic            rst,
  wire_seq_ctrl_if.slave  bus
);
`ifdef WIRE_SEQ_STRIKES_EN
  localparam int STRIKE_LIMIT = MAX_STRIKES;
`else
  // MAX_STRIKES has no effect in this build: a single strike is fatal.
  localparam int STRIKE_LIMIT = MAX_STRIKES - MAX_STRIKES + 1;
`endif
  localparam logic [STRIKE_W-1:0] STRIKE_MAX = STRIKE_W'(STRIKE_LIMIT);

  state_e                 state_q, state_d;
  logic [WIRE_IDX_W-1:0]  step_q, step_d;
  logic [STRIKE_W-1:0]    strikes_q, strikes_d;
  logic                   strike_p_q, strike_p_d;
  logic                   arm_err_q, arm_err_d;
  logic [NUM_WIRES-1:0]   cut_mask_q, cut_mask_d;
  logic [NUM_WIRES-1:0]   prev_q, prev_d;
  logic [3*NUM_WIRES-1:0] order_q, order_d;

  logic [NUM_WIRES-1:0]   cut_vec;
  logic                   single_cut, multi_cut;
  logic [WIRE_IDX_W-1:0]  cut_idx;
  logic                   arm_ok;
  logic [WIRE_IDX_W-1:0]  exp_idx;

  wire_cut_detect #(.NUM_WIRES(NUM_WIRES)) u_detect (
    .prev       (prev_q),
    .wire_lvl   (bus.wire_lvl),
    .cut_mask   (cut_mask_q),
    .cut_vec    (cut_vec),
    .single_cut (single_cut),
    .multi_cut  (multi_cut),
    .cut_idx    (cut_idx)
  );

  // Arm is only valid with all wires intact and a duplicate-free, in-range order.
  always_comb begin
    arm_ok = &bus.wire_lvl;
    for (int i = 0; i < SEQ_LEN; i++) begin
      if (int'(bus.order[3*i +: 3]) >= NUM_WIRES) arm_ok = 1'b0;
      for (int j = 0; j < i; j++) begin
        if (bus.order[3*i +: 3] == bus.order[3*j +: 3]) arm_ok = 1'b0;
      end
    end
  end

  always_comb begin
    exp_idx = '0;
    for (int k = 0; k < SEQ_LEN; k++) begin
      if (step_q == WIRE_IDX_W'(k)) exp_idx = order_q[3*k +: 3];
    end
  end

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    strikes_d  = strikes_q;
    strike_p_d = 1'b0;
    arm_err_d  = 1'b0;
    cut_mask_d = cut_mask_q;
    prev_d     = prev_q;
    order_d    = order_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.arm) begin
          if (arm_ok) begin
            state_d    = ST_ARMED;
            order_d    = bus.order;
            step_d     = '0;
            strikes_d  = '0;
            cut_mask_d = '0;
            prev_d     = bus.wire_lvl;
          end else begin
            arm_err_d = 1'b1;
          end
        end
      end
      ST_ARMED: begin
        prev_d     = bus.wire_lvl;
        cut_mask_d = cut_mask_q | cut_vec;
        // Timeout beats everything, including a simultaneous final correct cut.
        if (bus.timeout) begin
          state_d = ST_EXPLODED;
        end else if (single_cut && cut_idx == exp_idx) begin
          step_d = step_q + 1'b1;
          if (step_q == WIRE_IDX_W'(SEQ_LEN - 1)) state_d = ST_DEFUSED;
        end else if (single_cut || multi_cut) begin
          strike_p_d = 1'b1;
          strikes_d  = sat_inc(strikes_q, STRIKE_MAX);
          if (strikes_d == STRIKE_MAX) state_d = ST_EXPLODED;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      step_q     <= '0;
      strikes_q  <= '0;
      strike_p_q <= 1'b0;
      arm_err_q  <= 1'b0;
      cut_mask_q <= '0;
      prev_q     <= '1;
      order_q    <= '0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      strikes_q  <= strikes_d;
      strike_p_q <= strike_p_d;
      arm_err_q  <= arm_err_d;
      cut_mask_q <= cut_mask_d;
      prev_q     <= prev_d;
      order_q    <= order_d;
    end
  end

  assign bus.state    = state_q;
  assign bus.step     = step_q;
  assign bus.strikes  = strikes_q;
  assign bus.strike_p = strike_p_q;
  assign bus.arm_err  = arm_err_q;
endmodule
